// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider, one quotient bit per cycle.
// Fixed latency of WIDTH+1 cycles from the accepting edge to the done pulse.
// Optional build macro DIV_SIGNED_EN adds two's-complement division
// (magnitude conversion, sign fix-up and MIN/-1 overflow detection).
module iter_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t            state, state_nxt;
    logic [WIDTH:0]    rem;        // one spare bit so compare/subtract never overflows
    logic [WIDTH-1:0]  quo;        // holds remaining dividend bits, fills with quotient bits
    logic [WIDTH-1:0]  dvs;
    logic [WIDTH-1:0]  dvd_orig;   // original dividend, returned on divide-by-zero
    logic [CNT_W-1:0]  count;
    logic              dbz;
    logic              ovf;

    logic [WIDTH-1:0]  dvd_mag, dvs_mag;
    logic [WIDTH-1:0]  q_fix, r_fix;
    logic [WIDTH:0]    rem_sh, rem_nxt;
    logic [WIDTH-1:0]  quo_nxt;
    logic [WIDTH-1:0]  q_res, r_res;
    logic              v_res;
    logic              accept;

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);

`ifdef DIV_SIGNED_EN
    logic sgn_in, a_neg, b_neg;
    logic q_neg, r_neg;

    assign sgn_in  = signed_op;
    assign a_neg   = sgn_in & dividend[WIDTH-1];
    assign b_neg   = sgn_in & divisor[WIDTH-1];
    assign dvd_mag = a_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = b_neg ? (~divisor + 1'b1) : divisor;
    assign q_fix   = q_neg ? (~quo + 1'b1) : quo;
    assign r_fix   = r_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];

    // Capture sign bookkeeping and the MIN / -1 overflow case at accept
    always_ff @(posedge clk) begin
        if (reset) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            ovf   <= sgn_in && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                            && (divisor == {WIDTH{1'b1}});
        end
    end

    logic unused_bits;
    assign unused_bits = rem[WIDTH];
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_fix   = quo;
    assign r_fix   = rem[WIDTH-1:0];
    assign ovf     = 1'b0;

    // signed_op has no effect in the unsigned-only build
    logic unused_bits;
    assign unused_bits = ^{rem[WIDTH], signed_op};
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        quo_nxt = {quo[WIDTH-2:0], 1'b0};
        rem_nxt = rem_sh;
        if (rem_sh >= {1'b0, dvs}) begin
            rem_nxt    = rem_sh - {1'b0, dvs};
            quo_nxt[0] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITER;
            ITER:    if (count == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration datapath: load operands on accept, step once per ITER cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dvd_orig <= '0;
            count    <= '0;
            dbz      <= 1'b0;
        end else if (accept) begin
            rem      <= '0;
            quo      <= dvd_mag;
            dvs      <= dvs_mag;
            dvd_orig <= dividend;
            count    <= '0;
            dbz      <= (divisor == '0);
        end else if (state == ITER) begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            count <= count + 1'b1;
        end
    end

    // Final result with divide-by-zero and overflow overrides
    always_comb begin
        q_res = q_fix;
        r_res = r_fix;
        v_res = 1'b0;
        if (dbz) begin
            q_res = '1;
            r_res = dvd_orig;
            v_res = 1'b1;
        end else if (ovf) begin
            q_res = {1'b1, {(WIDTH-1){1'b0}}};
            r_res = '0;
            v_res = 1'b1;
        end
    end

    // Register results and pulse done in FIX; outputs hold until the next done
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            flags     <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                quotient  <= q_res;
                remainder <= r_res;
                flags     <= {q_res[WIDTH-1], (q_res == '0), 1'b0, v_res};
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider (WIDTH=16) with a cycle-level reference
// model checked every cycle, plus literal expectations per operation.
module tb_iter_divider;
    localparam int W = 16;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset, start, signed_op;
    logic [W-1:0] dividend, divisor;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;
    logic [3:0]   flags;

    int errors = 0;
    int checks = 0;
    int ndone  = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .flags(flags)
    );

    always #5 clk = ~clk;

    // Arithmetic reference for one division
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic [3:0] f);
        logic sg;
        logic v;
        int sa, sb;
        sg = s;
`ifndef DIV_SIGNED_EN
        sg = 1'b0;
`endif
        v = 1'b0;
        if (b == 0) begin
            q = '1; r = a; v = 1'b1;
        end else if (sg && a == 16'h8000 && b == 16'hFFFF) begin
            q = 16'h8000; r = '0; v = 1'b1;
        end else if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        f = {q[W-1], (q == 0), 1'b0, v};
    endfunction

    // Cycle-level model: accept when idle, result after LAT edges
    logic         m_ok = 1'b0, m_busy, m_done;
    int           m_left;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    logic [3:0]   m_f, p_f;

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            m_q = '0; m_r = '0; m_f = '0;
        end else if (m_ok) begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_q = p_q; m_r = p_r; m_f = p_f;
                end
            end else if (start) begin
                ref_div(dividend, divisor, signed_op, p_q, p_r, p_f);
                m_busy = 1'b1;
                m_left = LAT;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_ok) begin
            checks++;
            if ({busy, done, quotient, remainder, flags} !==
                {m_busy, m_done, m_q, m_r, m_f}) begin
                errors++;
                $display("FAIL cycle_model t=%0t: busy/done/q/r/f got %b/%b/%h/%h/%b expected %b/%b/%h/%h/%b",
                         $time, busy, done, quotient, remainder, flags,
                         m_busy, m_done, m_q, m_r, m_f);
            end
            if (done === 1'b1) ndone++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle (returns at the negedge after the accepting edge)
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done with a bound; lat counts negedges after the accepting edge
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 3 * LAT) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, 3 * LAT);
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic [3:0] ef);
        int lat;
        launch(a, b, s);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(name, lat);
        chk({name, "_lat"}, 32'(lat), 32'(LAT));
        chk({name, "_q"}, 32'(quotient), 32'(eq));
        chk({name, "_r"}, 32'(remainder), 32'(er));
        chk({name, "_flags"}, 32'(flags), 32'(ef));
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, d0;
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        // reset together with start: reset wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("u100_7",   16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    4'b0000);
        do_op("dbz",      16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 4'b1001);
        do_op("zero_zero",16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 4'b1001);
        do_op("u_min_m1", 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 4'b0100);
        do_op("u_max_1",  16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 4'b1000);
        do_op("u_max_max",16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 4'b0000);
        do_op("u_small",  16'd3,    16'd200,  1'b0, 16'h0000, 16'd3,    4'b0100);
`ifdef DIV_SIGNED_EN
        do_op("s_m100_7", 16'hFF9C, 16'd7,    1'b1, 16'hFFF2, 16'hFFFE, 4'b1000);
        do_op("s_ovf",    16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 4'b1001);
        do_op("s_100_m7", 16'd100,  16'hFFF9, 1'b1, 16'hFFF2, 16'd2,    4'b1000);
        do_op("s_m100_m7",16'hFF9C, 16'hFFF9, 1'b1, 16'd14,   16'hFFFE, 4'b0000);
`else
        // signed_op ignored: 0xFF9C / 7 = 65436 / 7 = 9348 r 0
        do_op("s_ignored", 16'hFF9C, 16'd7,   1'b1, 16'h2484, 16'h0000, 4'b0000);
`endif

        // start pulsed mid-operation is ignored
        launch(16'd200, 16'd9, 1'b0);
        d0 = ndone;
        repeat (4) @(negedge clk);
        dividend = 16'd5; divisor = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * LAT) @(negedge clk);
        #1;
        chk("busy_start_ndone", 32'(ndone - d0), 32'd1);
        chk("busy_start_q", 32'(quotient), 32'd22);
        chk("busy_start_r", 32'(remainder), 32'd2);

        // start held during the done cycle is accepted
        launch(16'd81, 16'd4, 1'b0);
        wait_done("b2b_a", lat);
        chk("b2b_a_q", 32'(quotient), 32'd20);
        dividend = 16'd1000; divisor = 16'd33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        wait_done("b2b_b", lat);
        chk("b2b_b_lat", 32'(lat), 32'(LAT));
        chk("b2b_b_q", 32'(quotient), 32'd30);
        chk("b2b_b_r", 32'(remainder), 32'd10);
        @(negedge clk);

        // reset mid-iteration aborts the op with no done pulse
        launch(16'd50, 16'd5, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        reset = 1'b0;
        d0 = ndone;
        repeat (2 * LAT) @(negedge clk);
        #1;
        chk("abort_no_done", 32'(ndone - d0), 32'd0);
        @(negedge clk);
        do_op("after_abort", 16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
